scrambler_loader: RTL and testbench
===================================

Name: scrambler_loader

Overview:
Upstream feeder for scrambler2. Accepts a byte stream on a valid/ready interface and writes each byte into the scrambler's buffer through its user write port (w_addr/din/wr_en). At end-of-frame it launches the scrambler with start/len_1 and holds off new input until the scrambler's busy falls. Frames longer than 32 bytes are truncated and flagged.

Parameters:
ADDR_W, 16, width of scrambler buffer address
BASE_ADDR, 16'hF050, buffer address of byte 0 of every frame
MAX_LEN, 32, maximum bytes per frame (len_1 is 5 bits; must be 32)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous reset, active low
s_valid  in  1  input byte valid
s_data  in  8  input byte
s_last  in  1  marks final byte of frame
s_ready  out  1  loader can accept byte
scr_w_addr  out  ADDR_W  to scrambler usr_w_addr
scr_din  out  8  to scrambler usr_din
scr_wr_en  out  1  to scrambler usr_wr_en
scr_start  out  1  to scrambler start
scr_len_1  out  5  to scrambler len_1 (frame length minus 1)
scr_busy  in  1  from scrambler busy
frame_done  out  1  one-cycle pulse when scrambler finishes a frame
trunc  out  1  frame was truncated (sticky until next frame starts)

Behaviour:
- One clock (clk). Reset is synchronous and active-low (rst_n). It is sampled on the clk rising edge and overrides everything, including mid-frame.
- Reset values: state IDLE, s_ready 0, scr_w_addr BASE_ADDR, scr_din 0, scr_wr_en 0, scr_start 0, scr_len_1 0, frame_done 0, trunc 0, cnt 0.
- Handshake: a byte is accepted on a cycle where s_valid && s_ready. s_ready is a registered output and depends only on state.
- States:
  IDLE: s_ready=1. The first accepted byte clears trunc and goes to LOAD. The byte is processed exactly as in LOAD.
  LOAD: s_ready=1. For each accepted byte, the next cycle has scr_wr_en=1, scr_w_addr=BASE_ADDR+cnt and scr_din=s_data. cnt then increments. This gives one cycle of write latency, with back-to-back writes allowed. If the accepted byte has s_last=1, go to KICK. If it is byte number MAX_LEN (cnt==31) and s_last=0, set trunc=1 and go to DRAIN.
  DRAIN: s_ready=1. Accepted bytes are discarded with no writes. On an accepted byte with s_last=1, go to KICK.
  KICK: s_ready=0. scr_len_1=cnt-1 (mod 32). Hold scr_start=1 until scr_busy is sampled 1, then drop scr_start and go to WAIT.
  WAIT: s_ready=0. When scr_busy is sampled 0, pulse frame_done for 1 cycle, reset cnt=0, and return to IDLE.
- The last buffer write completes in the same cycle KICK is entered. scr_start is therefore never asserted before the final write has been issued.
- Address arithmetic is ADDR_W bits and wraps modulo 2^ADDR_W. cnt is 6 bits.
- A single-byte frame (s_last on the first byte) gives scr_len_1=0.
- scr_len_1 is held stable from KICK through WAIT.
- s_valid while s_ready=0 is ignored and the byte is not lost: the source holds it per the handshake rules.
- A reset during KICK or WAIT abandons the frame. scr_start drops on the next edge, and the scrambler run is not tracked.

Decomposition:
- Shared package scrambler_pkg holds BASE_ADDR, MAX_LEN, the LEN_W=5 constant and the loader state encoding (IDLE, LOAD, DRAIN, KICK, WAIT). scrambler2 and its bench use the same constants.
- No sub-module is needed. The FSM, the counter and the write register live in one module.

Test Plan:
- Load 10 bytes 0x01..0x0A, s_last on the 10th, s_valid held high. Required: writes to 0xF050..0xF059 with data 0x01..0x0A on consecutive cycles; scr_len_1=9; scr_start high until busy; frame_done pulse after busy falls; s_ready=0 during KICK and WAIT.
- Single byte 0x5A with s_last. Required: one write at 0xF050; scr_len_1=0; trunc=0.
- Send 40 bytes with s_last on the 40th. Required: exactly 32 writes (0xF050..0xF06F); trunc=1; 8 bytes accepted and dropped; scr_len_1=31.
- Toggle s_valid randomly during a 5-byte frame. Required: writes only for handshaked bytes, addresses contiguous, scr_len_1=4.
- Assert rst_n=0 for 1 cycle during WAIT. Required: next cycle shows all outputs at reset values and s_ready=1. A following 3-byte frame starts again at 0xF050.
- Run two frames back-to-back. Required: the second frame is not accepted until frame_done; its addresses restart at 0xF050; trunc clears when its first byte is accepted.

Source files
------------

// File: rtl/scrambler_pkg.sv
// Constants and loader state encoding shared by scrambler2, its loader and their benches.
package scrambler_pkg;

  localparam int              SCR_ADDR_W    = 16;
  localparam logic [15:0]     SCR_BASE_ADDR = 16'hF050;
  localparam int              SCR_MAX_LEN   = 32;
  localparam int              LEN_W         = 5;
  localparam int              CNT_W         = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_KICK  = 3'd3,
    ST_WAIT  = 3'd4
  } loader_state_e;

  // Frame length minus one, folded into the scrambler's len_1 field (mod 32).
  function automatic logic [LEN_W-1:0] len_from_cnt(input logic [CNT_W-1:0] cnt);
    logic [CNT_W-1:0] m;
    m = cnt - 1'b1;
    return m[LEN_W-1:0];
  endfunction

endpackage

// File: rtl/scrambler_loader.sv
// Feeds a byte stream into scrambler2's buffer, then launches the scrambler
// on end-of-frame and waits for it to finish before taking the next frame.
//
// Handshake: a byte transfers on a rising edge where s_valid && s_ready are
// both 1. s_ready is registered and is a function of state only; the source
// must hold s_valid/s_data/s_last stable until the transfer happens.
module scrambler_loader
  import scrambler_pkg::*;
#(
  parameter int                ADDR_W    = SCR_ADDR_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(SCR_BASE_ADDR),
  parameter int                MAX_LEN   = SCR_MAX_LEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic [ADDR_W-1:0] scr_w_addr,
  output logic [7:0]        scr_din,
  output logic              scr_wr_en,
  output logic              scr_start,
  output logic [LEN_W-1:0]  scr_len_1,
  input  logic              scr_busy,
  output logic              frame_done,
  output logic              trunc,
  output loader_state_e     dbg_state
);

  // Index of the last byte that still fits in the buffer.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_LEN - 1);

  loader_state_e     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              s_ready_q, s_ready_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [7:0]        din_q, din_d;
  logic              wr_en_q, wr_en_d;
  logic              start_q, start_d;
  logic [LEN_W-1:0]  len_1_q, len_1_d;
  logic              frame_done_q, frame_done_d;
  logic              trunc_q, trunc_d;
  logic              accept;

  assign accept = s_valid && s_ready_q;

  // Next-state logic for the FSM, byte counter and buffer write register.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    w_addr_d     = w_addr_q;
    din_d        = din_q;
    wr_en_d      = 1'b0;
    start_d      = start_q;
    len_1_d      = len_1_q;
    frame_done_d = 1'b0;
    trunc_d      = trunc_q;

    case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (accept) begin
          // A fresh frame clears the previous frame's truncation flag.
          if (state_q == ST_IDLE) trunc_d = 1'b0;
          wr_en_d  = 1'b1;
          w_addr_d = BASE_ADDR + ADDR_W'(cnt_q);
          din_d    = s_data;
          cnt_d    = cnt_q + 1'b1;
          if (s_last) begin
            // Start rises together with the final write reaching the buffer.
            state_d = ST_KICK;
            start_d = 1'b1;
            len_1_d = len_from_cnt(cnt_d);
          end else if (cnt_q == LAST_IDX) begin
            trunc_d = 1'b1;
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_DRAIN: begin
        // Overflow bytes are swallowed; cnt stays at MAX_LEN.
        if (accept && s_last) begin
          state_d = ST_KICK;
          start_d = 1'b1;
          len_1_d = len_from_cnt(cnt_q);
        end
      end
      ST_KICK: begin
        if (scr_busy) begin
          start_d = 1'b0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!scr_busy) begin
          frame_done_d = 1'b1;
          cnt_d        = '0;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        start_d = 1'b0;
        cnt_d   = '0;
      end
    endcase

    s_ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD) || (state_d == ST_DRAIN);
  end

  // Single register bank for FSM state and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      s_ready_q    <= 1'b0;
      w_addr_q     <= BASE_ADDR;
      din_q        <= '0;
      wr_en_q      <= 1'b0;
      start_q      <= 1'b0;
      len_1_q      <= '0;
      frame_done_q <= 1'b0;
      trunc_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      s_ready_q    <= s_ready_d;
      w_addr_q     <= w_addr_d;
      din_q        <= din_d;
      wr_en_q      <= wr_en_d;
      start_q      <= start_d;
      len_1_q      <= len_1_d;
      frame_done_q <= frame_done_d;
      trunc_q      <= trunc_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign scr_w_addr = w_addr_q;
  assign scr_din    = din_q;
  assign scr_wr_en  = wr_en_q;
  assign scr_start  = start_q;
  assign scr_len_1  = len_1_q;
  assign frame_done = frame_done_q;
  assign trunc      = trunc_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_scrambler_loader.sv
// Directed bench for scrambler_loader: drives frames byte by byte, plays the
// scrambler's busy line by hand and scoreboards every buffer write.
module tb_scrambler_loader;
  import scrambler_pkg::*;

  localparam logic [15:0] EXP_BASE = 16'hF050;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid;
  logic [7:0]    s_data;
  logic          s_last;
  logic          s_ready;
  logic [15:0]   scr_w_addr;
  logic [7:0]    scr_din;
  logic          scr_wr_en;
  logic          scr_start;
  logic [4:0]    scr_len_1;
  logic          scr_busy;
  logic          frame_done;
  logic          trunc;
  loader_state_e dbg_state;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [23:0] exp_q[$];
  int          wr_count = 0;
  int          model_cnt = 0;
  int          cyc = 0;
  int          first_wr_cyc = 0;
  int          last_wr_cyc = 0;

  scrambler_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .scr_w_addr (scr_w_addr),
    .scr_din    (scr_din),
    .scr_wr_en  (scr_wr_en),
    .scr_start  (scr_start),
    .scr_len_1  (scr_len_1),
    .scr_busy   (scr_busy),
    .frame_done (frame_done),
    .trunc      (trunc),
    .dbg_state  (dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write must match the head of the expected queue
  always @(negedge clk) begin
    if (scr_wr_en === 1'b1) begin
      if (wr_count == 0) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
      wr_count++;
      check("write_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("write_addr_data", {8'h00, scr_w_addr, scr_din}, {8'h00, exp_q.pop_front()});
    end
  end

  // Driver: optional idle gap, then present a byte and hold it until taken
  task automatic send_byte(input logic [7:0] d, input logic last, input int gap);
    int t;
    t = 0;
    repeat (gap) begin
      @(negedge clk);
      s_valid = 1'b0;
      s_data  = 8'($urandom);
      s_last  = 1'($urandom);
    end
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (s_ready !== 1'b1 && t < 64) begin
      @(negedge clk);
      t++;
    end
    check("send_timeout", 32'(t < 64), 32'd1);
    if (model_cnt < 32) exp_q.push_back({EXP_BASE + 16'(model_cnt), d});
    model_cnt++;
  endtask

  task automatic end_input();
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic new_frame();
    model_cnt = 0;
    wr_count  = 0;
  endtask

  // Called at the first KICK negedge; leaves the DUT in WAIT with busy high
  task automatic kick_to_wait(input string tag, input int exp_len, input logic exp_trunc);
    check({tag, "_kick_state"}, 32'(dbg_state), 32'(ST_KICK));
    check({tag, "_kick_start"}, 32'(scr_start), 32'd1);
    check({tag, "_kick_ready"}, 32'(s_ready), 32'd0);
    check({tag, "_kick_len"},   32'(scr_len_1), 32'(exp_len));
    check({tag, "_kick_trunc"}, 32'(trunc), 32'(exp_trunc));
    @(negedge clk);
    check({tag, "_start_held"}, 32'(scr_start), 32'd1);
    scr_busy = 1'b1;
    @(negedge clk);
    check({tag, "_wait_state"}, 32'(dbg_state), 32'(ST_WAIT));
    check({tag, "_wait_start"}, 32'(scr_start), 32'd0);
    check({tag, "_wait_ready"}, 32'(s_ready), 32'd0);
    check({tag, "_wait_len"},   32'(scr_len_1), 32'(exp_len));
  endtask

  task automatic wait_to_idle(input string tag, input int exp_len, input logic exp_trunc, input int exp_writes);
    @(negedge clk);
    check({tag, "_fd_early"}, 32'(frame_done), 32'd0);
    scr_busy = 1'b0;
    @(negedge clk);
    check({tag, "_fd_pulse"}, 32'(frame_done), 32'd1);
    check({tag, "_idle_state"}, 32'(dbg_state), 32'(ST_IDLE));
    check({tag, "_idle_ready"}, 32'(s_ready), 32'd1);
    check({tag, "_len_held"}, 32'(scr_len_1), 32'(exp_len));
    check({tag, "_trunc"}, 32'(trunc), 32'(exp_trunc));
    @(negedge clk);
    check({tag, "_fd_one_cycle"}, 32'(frame_done), 32'd0);
    check({tag, "_writes"}, 32'(wr_count), 32'(exp_writes));
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_values(input string tag, input logic exp_ready);
    check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    check({tag, "_ready"}, 32'(s_ready), 32'(exp_ready));
    check({tag, "_addr"},  32'(scr_w_addr), 32'hF050);
    check({tag, "_din"},   32'(scr_din), 32'd0);
    check({tag, "_wr_en"}, 32'(scr_wr_en), 32'd0);
    check({tag, "_start"}, 32'(scr_start), 32'd0);
    check({tag, "_len"},   32'(scr_len_1), 32'd0);
    check({tag, "_fd"},    32'(frame_done), 32'd0);
    check({tag, "_trunc"}, 32'(trunc), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; scr_busy = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset", 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_ready", 32'(s_ready), 32'd1);

    // 1: ten bytes back to back
    new_frame();
    for (int i = 1; i <= 10; i++) send_byte(8'(i), (i == 10), 0);
    end_input();
    kick_to_wait("t1", 9, 1'b0);
    wait_to_idle("t1", 9, 1'b0, 10);
    check("t1_back_to_back", 32'(last_wr_cyc - first_wr_cyc), 32'd9);

    // 2: single-byte frame
    new_frame();
    send_byte(8'h5A, 1'b1, 0);
    end_input();
    kick_to_wait("t2", 0, 1'b0);
    wait_to_idle("t2", 0, 1'b0, 1);

    // 3: 40 bytes, only 32 land in the buffer
    new_frame();
    for (int i = 0; i < 40; i++) begin
      send_byte(8'(8'h80 + i), (i == 39), 0);
      if (i == 33) check("t3_drain_state", 32'(dbg_state), 32'(ST_DRAIN));
    end
    end_input();
    kick_to_wait("t3", 31, 1'b1);
    wait_to_idle("t3", 31, 1'b1, 32);

    // 4: five bytes with s_valid toggling; trunc clears on first byte
    new_frame();
    check("t4_trunc_before", 32'(trunc), 32'd1);
    send_byte(8'hE0, 1'b0, $urandom_range(0, 3));
    @(negedge clk);
    s_valid = 1'b0;
    check("t4_trunc_cleared", 32'(trunc), 32'd0);
    check("t4_load_state", 32'(dbg_state), 32'(ST_LOAD));
    for (int i = 1; i < 5; i++) send_byte(8'(8'hE0 + i), (i == 4), $urandom_range(0, 3));
    end_input();
    kick_to_wait("t4", 4, 1'b0);
    wait_to_idle("t4", 4, 1'b0, 5);

    // 5: reset during WAIT, then a 3-byte frame restarts at the base address
    new_frame();
    send_byte(8'hC1, 1'b0, 0);
    send_byte(8'hC2, 1'b1, 0);
    end_input();
    kick_to_wait("t5", 1, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    scr_busy = 1'b0;
    check_reset_values("t5_rst", 1'b0);
    @(negedge clk);
    check("t5_ready_after_rst", 32'(s_ready), 32'd1);
    check("t5_no_fd_after_rst", 32'(frame_done), 32'd0);
    new_frame();
    for (int i = 1; i <= 3; i++) send_byte(8'(8'hD0 + i), (i == 3), 0);
    end_input();
    kick_to_wait("t5b", 2, 1'b0);
    wait_to_idle("t5b", 2, 1'b0, 3);

    // 6: truncated frame followed immediately by a pending second frame
    new_frame();
    for (int i = 0; i < 33; i++) send_byte(8'(8'h40 + i), (i == 32), 0);
    end_input();
    kick_to_wait("t6a", 31, 1'b1);
    s_valid = 1'b1; s_data = 8'hA1; s_last = 1'b0;
    @(negedge clk);
    check("t6_blocked_ready", 32'(s_ready), 32'd0);
    check("t6_blocked_state", 32'(dbg_state), 32'(ST_WAIT));
    scr_busy = 1'b0;
    new_frame();
    exp_q.push_back({EXP_BASE, 8'hA1});
    model_cnt = 1;
    @(negedge clk);
    check("t6_fd_pulse", 32'(frame_done), 32'd1);
    check("t6_ready_at_fd", 32'(s_ready), 32'd1);
    check("t6_trunc_still", 32'(trunc), 32'd1);
    @(negedge clk);
    check("t6_trunc_cleared", 32'(trunc), 32'd0);
    check("t6_load_state", 32'(dbg_state), 32'(ST_LOAD));
    s_valid = 1'b0;
    send_byte(8'hA2, 1'b1, 0);
    end_input();
    kick_to_wait("t6b", 1, 1'b0);
    wait_to_idle("t6b", 1, 1'b0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
